demux_dispatch_ctrl: RTL and testbench
======================================

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous and active-high.
REQ-004 Port: IN_VALID  input  1  upstream word present.
REQ-005 Port: IN_READY  output  1  controller accepts the word this cycle.
REQ-006 Port: IN_DATA  input  WIDTH  upstream word.
REQ-007 Port: OUT_DATA  output  WIDTH  held word, shared by all four lanes.
REQ-008 Port: OUT_VALID  output  4  one-hot lane valid; bit n = lane n.
REQ-009 Port: OUT_READY  input  4  per-lane consumer ready.
REQ-010 Port: SEL  output  2  current lane select (S1 = SEL[1], S0 = SEL[0]).

Function
REQ-011 The block SHALL be a one-entry buffered round-robin dispatcher with two states: EMPTY and HOLD.
REQ-012 Accept event SHALL be IN_VALID & IN_READY.
REQ-013 Send event SHALL be HOLD & OUT_READY[SEL].
REQ-014 IN_READY SHALL be combinational: 1 in EMPTY, OUT_READY[SEL] in HOLD, 0 while RST is high.
REQ-015 On accept, the block SHALL register IN_DATA to OUT_DATA, enter or remain in HOLD, and latch SEL.
REQ-016 Latched SEL SHALL be the first lane n, in order PTR, PTR+1, PTR+2, PTR+3 (mod 4), with OUT_READY[n]=1 in the accept cycle; if no lane is ready, SEL SHALL be PTR.
REQ-017 PTR SHALL be the value after any same-cycle send update.
REQ-018 SEL and OUT_DATA SHALL be stable throughout HOLD until send; there is no re-arbitration while holding.
REQ-019 OUT_VALID SHALL be one-hot at SEL in HOLD and 4'b0000 in EMPTY.
REQ-020 On send, PTR SHALL become SEL+1 mod 4 (3 wraps to 0).
REQ-021 Send without accept SHALL move the state HOLD->EMPTY.
REQ-022 Send with accept in the same cycle SHALL keep the state in HOLD with the new word and new SEL; zero-bubble throughput is one word per cycle.
REQ-023 Latency SHALL be one cycle: a word accepted at edge k is visible on OUT_* after edge k.
REQ-024 When IN_VALID=0 in EMPTY, no state SHALL change.

Reset
REQ-025 While RST is high, the block SHALL asynchronously force: state EMPTY, PTR 0, SEL 2'b00, OUT_DATA 0, OUT_VALID 0, IN_READY 0.
REQ-026 A word held when RST asserts SHALL be discarded and never presented after release.
REQ-027 The first edge after RST deasserts SHALL be able to accept a word.

Configuration
REQ-028 Macro DEMUX_DISPATCH_STATS_EN is the single configuration macro.
REQ-029 With DEMUX_DISPATCH_STATS_EN defined:
- Output CNT of width 4x8 SHALL be added; byte n counts sends on lane n.
- Each count SHALL saturate at 255.
- All counts SHALL be cleared by RST.
REQ-030 Without DEMUX_DISPATCH_STATS_EN, the CNT port and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package demux_dispatch_pkg SHALL hold:
- NUM_LANES = 4
- SEL_W = 2
- the state enum {EMPTY, HOLD}
- the saturation constant CNT_MAX = 255
REQ-032 OUT_VALID SHALL be produced by one instance of the existing demux_1x4 with A = (state==HOLD), S1/S0 = SEL.
REQ-033 The round-robin first-ready search SHALL be a function in the package, not a separate module.

Verification
REQ-034 Reset with all OUT_READY=1111: send words 0x11,0x22,0x33,0x44,0x55 back-to-back -> lanes 0,1,2,3,0; one word per cycle; IN_READY held at 1.
REQ-035 With PTR=1, OUT_READY=0100, send 0xA5 -> SEL=2, OUT_VALID=0100, send next cycle, PTR becomes 3.
REQ-036 With OUT_READY=0000, accept 0x3C -> HOLD on SEL=PTR with IN_READY=0 for 5 cycles and OUT_DATA stable; raise OUT_READY[PTR] -> send, return to EMPTY.
REQ-037 With PTR=3, send on lane 3 -> PTR wraps to 0, and the next word with all lanes ready goes to lane 0.
REQ-038 Assert RST mid-HOLD holding 0x7E -> OUT_VALID=0 immediately (asynchronous), and 0x7E never appears after release.
REQ-039 With DEMUX_DISPATCH_STATS_EN defined, send 300 words to lane 2 only -> CNT byte 2 = 255 and other bytes = 0.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared constants, state encoding and round-robin lane search for demux_dispatch_ctrl.
package demux_dispatch_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_MAX   = 255;

  typedef enum logic {
    EMPTY,
    HOLD
  } state_t;

  // First ready lane scanning ptr, ptr+1, ... (mod NUM_LANES); falls back to ptr.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0]     ptr,
                                                input logic [NUM_LANES-1:0] ready);
    logic             found;
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && ready[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_demux_1x4.sv
// 1-to-4 demultiplexer: routes A onto Y[{S1,S0}], other outputs low.
module demux_1x4 (
  input  logic       A,
  input  logic       S1,
  input  logic       S0,
  output logic [3:0] Y
);

  always_comb begin
    Y = '0;
    Y[{S1, S0}] = A;
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-entry buffered round-robin dispatcher onto four lanes sharing OUT_DATA.
// Optional per-lane saturating send counters on CNT: define DEMUX_DISPATCH_STATS_EN.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [3:0]       OUT_VALID,
  input  logic [3:0]       OUT_READY,
  output logic [1:0]       SEL
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [4*8-1:0]   CNT
`endif
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, sel, ptr_eff;
  logic [WIDTH-1:0] data;
  logic             hold, accept, send;

  assign hold   = (state == HOLD);
  assign send   = hold & OUT_READY[sel];
  assign accept = IN_VALID & IN_READY;
  // Search starts from the pointer as already advanced by a same-cycle send.
  assign ptr_eff = send ? sel + SEL_W'(1) : ptr;

  always_comb begin
    IN_READY = 1'b0;
    if (!RST) IN_READY = hold ? OUT_READY[sel] : 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (accept)    state_nxt = HOLD;
    else if (send) state_nxt = EMPTY;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr  <= '0;
      sel  <= '0;
      data <= '0;
    end else begin
      if (send) ptr <= sel + SEL_W'(1);
      if (accept) begin
        sel  <= rr_pick(ptr_eff, OUT_READY);
        data <= IN_DATA;
      end
    end
  end

  assign SEL      = sel;
  assign OUT_DATA = data;

  demux_1x4 u_valid_demux (
    .A  (hold),
    .S1 (sel[1]),
    .S0 (sel[0]),
    .Y  (OUT_VALID)
  );

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [NUM_LANES-1:0][7:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (send && sel == SEL_W'(i) && cnt[i] != 8'(CNT_MAX))
          cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  assign CNT = cnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed and random checks of demux_dispatch_ctrl against a transaction-level lane model.
module tb_demux_dispatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_DATA = '0;
  logic [7:0] OUT_DATA;
  logic [3:0] OUT_VALID;
  logic [3:0] OUT_READY = '0;
  logic [1:0] SEL;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [31:0] CNT;
`endif

  int tests  = 0;
  int failed = 0;

  // Model: the held word (if any), its lane, the next round-robin start and send counts.
  bit         m_hold;
  int         m_ptr, m_sel;
  logic [7:0] m_data;
  int         m_cnt [4];

  demux_dispatch_ctrl #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SEL       (SEL)
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    .CNT       (CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_ptr  = 0;
    m_sel  = 0;
    m_data = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] r);
    bit acc, snd;
    int exp_rdy;
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = r;
    #1;
    exp_rdy = m_hold ? int'(r[m_sel]) : 1;
    chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
    chk("out_valid", 32'(OUT_VALID), m_hold ? (32'd1 << m_sel) : 32'd0);
    if (m_hold) begin
      chk("sel", 32'(SEL), 32'(m_sel));
      chk("out_data", 32'(OUT_DATA), 32'(m_data));
    end
`ifdef DEMUX_DISPATCH_STATS_EN
    for (int i = 0; i < 4; i++)
      chk("cnt", 32'(CNT[i*8 +: 8]), 32'(m_cnt[i]));
`endif
    acc = v && (exp_rdy == 1);
    snd = m_hold && r[m_sel];
    if (snd) begin
      if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
      m_ptr = (m_sel + 1) % 4;
    end
    if (acc) begin
      m_sel = m_ptr;
      for (int k = 0; k < 4; k++) begin
        if (r[(m_ptr + k) % 4]) begin
          m_sel = (m_ptr + k) % 4;
          break;
        end
      end
      m_data = d;
      m_hold = 1;
    end else if (snd) begin
      m_hold = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lanes [5];
    lanes = '{0, 1, 2, 3, 0};
    model_reset();

    // Reset state
    @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_sel", 32'(SEL), 32'd0);
    chk("rst_out_data", 32'(OUT_DATA), 32'd0);
    RST = 1'b0;

    // Back-to-back words with every lane ready
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h11 * (i + 1)), 4'b1111);
      chk("b2b_lane", 32'(SEL), 32'(lanes[i]));
      chk("b2b_data", 32'(OUT_DATA), 32'(8'h11 * (i + 1)));
      chk("b2b_in_ready", 32'(IN_READY), 32'd1);
    end
    step(1'b0, 8'h00, 4'b1111);   // drains 0x55, ptr -> 1

    // ptr=1 with only lane 2 ready
    step(1'b1, 8'hA5, 4'b0100);
    chk("a5_sel", 32'(SEL), 32'd2);
    chk("a5_valid", 32'(OUT_VALID), 32'b0100);
    step(1'b0, 8'h00, 4'b0100);   // ptr -> 3

    // ptr=3 wraps after a lane-3 send
    step(1'b1, 8'h99, 4'b1000);
    chk("wrap_sel3", 32'(SEL), 32'd3);
    step(1'b0, 8'h00, 4'b1000);
    step(1'b1, 8'h5A, 4'b1111);
    chk("wrap_sel0", 32'(SEL), 32'd0);
    step(1'b0, 8'h00, 4'b1111);   // ptr -> 1

    // No lane ready: hold on ptr
    step(1'b1, 8'h3C, 4'b0000);
    chk("stall_sel", 32'(SEL), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 4'b0000);
    step(1'b0, 8'h00, 4'b0010);
    chk("stall_empty", 32'(OUT_VALID), 32'd0);

    // Reset mid-hold discards the word
    step(1'b1, 8'h7E, 4'b0000);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_in_ready", 32'(IN_READY), 32'd0);
    chk("arst_data", 32'(OUT_DATA), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1'b0, 8'h00, 4'b1111);
    chk("arst_no_7e", 32'(OUT_VALID), 32'd0);
    step(1'b1, 8'h42, 4'b1111);
    chk("arst_first_accept", 32'(OUT_DATA), 32'h42);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));

`ifdef DEMUX_DISPATCH_STATS_EN
    RST = 1'b1;
    #1;
    chk("cnt_rst", CNT, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 4'b0100);
    step(1'b0, 8'h00, 4'b0100);
    chk("cnt_sat", CNT, 32'h00FF_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
